// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive bridge.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int BSY_TIMEOUT      = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        ISSUE_IDLE,
        ISSUE_REQ,
        WAIT_BSY,
        WAIT_DONE
    } issue_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO; pointers carry one wrap bit so full/empty fall out of the difference.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (wptr_q == rptr_q);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_rx_bridge.sv
// UART receiver feeding a bus master one write per byte through a small FIFO.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_bridge
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rx,
    output logic [DATA_WIDTH-1:0]         m_din,
    output logic                          m_execute,
    input  logic                          m_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int TW = $clog2(BSY_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BSY_TIMEOUT - 1);

    logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

    rx_state_e               rx_q, rx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_bad_q, par_bad_d;
    logic                    hold_q, hold_d;
    logic                    push, ferr_set, ovr_set;
    logic                    frame_err_q, frame_err_d, overrun_q, overrun_d;

    issue_state_e            is_q, is_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    pop;

    logic [DATA_WIDTH-1:0]   fifo_head;
    logic                    fifo_full, fifo_empty;

    byte_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (shift_q),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_comb begin
        rx_d      = rx_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        hold_d    = hold_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (rx_q)
            RX_IDLE: begin
                cnt_d     = '0;
                hold_d    = 1'b0;
                par_bad_d = 1'b0;
                if (rx_fall) rx_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    rx_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        rx_d = RX_PARITY;
`else
                        rx_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    rx_d  = RX_STOP;
                    if (rx_s2_q ^ (^shift_q)) begin
                        par_bad_d = 1'b1;
                        ferr_set  = 1'b1;
                    end
                end
            end
`endif
            RX_STOP: begin
                // After a low stop bit, park until the line idles so a break is not re-sampled.
                if (hold_q) begin
                    cnt_d = cnt_q;
                    if (rx_s2_q) rx_d = RX_IDLE;
                end else if (cnt_q == CNT_FULL) begin
                    if (rx_s2_q) begin
                        push = ~par_bad_q;
                        rx_d = RX_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        hold_d   = 1'b1;
                    end
                end
            end
            default: rx_d = RX_IDLE;
        endcase
    end

    assign ovr_set     = push & fifo_full & ~pop;
    assign frame_err_d = ferr_set | (frame_err_q & ~err_clr);
    assign overrun_d   = ovr_set  | (overrun_q  & ~err_clr);

    always_comb begin
        is_d  = is_q;
        din_d = din_q;
        tmo_d = tmo_q;
        pop   = 1'b0;
        case (is_q)
            ISSUE_IDLE: begin
                tmo_d = '0;
                if (!fifo_empty && !m_busy) begin
                    pop   = 1'b1;
                    din_d = fifo_head;
                    is_d  = ISSUE_REQ;
                end
            end
            ISSUE_REQ: is_d = WAIT_BSY;
            WAIT_BSY: begin
                // A master that never raises busy is assumed to have taken the byte.
                if (m_busy)                is_d  = WAIT_DONE;
                else if (tmo_q == TMO_LAST) is_d = ISSUE_IDLE;
                else                       tmo_d = tmo_q + 1'b1;
            end
            WAIT_DONE: if (!m_busy) is_d = ISSUE_IDLE;
            default:   is_d = ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_q        <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            hold_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            is_q        <= ISSUE_IDLE;
            din_q       <= '0;
            tmo_q       <= '0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            hold_q      <= hold_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            is_q        <= is_d;
            din_q       <= din_d;
            tmo_q       <= tmo_d;
        end
    end

    assign m_din     = din_q;
    assign m_execute = (is_q == ISSUE_REQ);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_bridge.md
# uart_rx_bridge

UART receiver and write-issuer that sits directly upstream of the TX/RX interface's bus master. It deserialises the external `rx` line into bytes, buffers them in a small FIFO, and feeds each byte to the master as one write transaction (`m_din` plus an `m_execute` pulse), pacing on `m_busy`. Line errors and overruns are flagged for firmware-visible status.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434 — clk cycles per UART bit (50 MHz / 115200); must be ≥ 8.
- `DATA_WIDTH`, 8 — bits per UART character and width of `m_din`.
- `FIFO_DEPTH`, 4 — receive buffer entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  — single clock.
- `rstn`  in  1  — reset, asynchronous, active-high (asserted at 1; name kept for consistency with the bus blocks).
- `rx`  in  1  — asynchronous UART line, idle high.
- `m_din`  out  DATA_WIDTH  — byte presented to the master.
- `m_execute`  out  1  — one-cycle write request to the master.
- `m_busy`  in  1  — master busy.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  — occupancy.
- `frame_err`  out  1  — sticky: stop bit sampled low.
- `overrun`  out  1  — sticky: byte received while FIFO full.
- `err_clr`  in  1  — one-cycle clear of sticky flags.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) before any use.
- Receive FSM: IDLE → START → DATA → STOP (→ PARITY between DATA and STOP when enabled).
  - IDLE: synchronised falling edge starts the bit counter, go START.
  - START: at CLKS_PER_BIT/2 (integer division) sample; high = false start → IDLE; low → DATA.
  - DATA: sample every CLKS_PER_BIT, shift in LSB first; after DATA_WIDTH samples → STOP.
  - STOP: sample after CLKS_PER_BIT. High: push byte into FIFO, → IDLE. Low: set `frame_err`, drop byte, stay in STOP until line high, then → IDLE.
- FIFO full at push: byte dropped, `overrun` set. Push and pop in the same cycle while full: both succeed, count unchanged.
- Issue FSM: ISSUE_IDLE → ISSUE_REQ → WAIT_BSY → WAIT_DONE.
  - ISSUE_IDLE: if FIFO non-empty and `m_busy`=0, pop head into `m_din` register, → ISSUE_REQ.
  - ISSUE_REQ: `m_execute`=1 for exactly this cycle, → WAIT_BSY.
  - WAIT_BSY: wait for `m_busy`=1 → WAIT_DONE; if not seen within 4 cycles, byte counted as delivered → ISSUE_IDLE.
  - WAIT_DONE: wait for `m_busy`=0 → ISSUE_IDLE.
- `m_din` held stable from ISSUE_REQ until the next pop.
- `err_clr` clears both sticky flags; a same-cycle set wins over clear.

## Timing
- Reset values: `m_din`=0, `m_execute`=0, `fifo_count`=0, `frame_err`=0, `overrun`=0; both FSMs idle; FIFO pointers 0.
- Reset mid-frame or mid-transaction: all state abandoned; no `m_execute` after release until a new complete frame arrives.
- `rx` edge to START entry: 3 cycles (2 sync + edge detect).
- Stop-bit sample to FIFO push: same cycle; `fifo_count` increments next cycle.
- Push into empty FIFO with master idle: `m_execute` asserts 2 cycles after the push edge.
- Back-to-back issues are separated by at least one ISSUE_IDLE cycle.
- `fifo_count` decrements the cycle after pop.

## Configuration
- `UART_RX_PARITY_EN` defined: one even-parity bit follows the data bits and is sampled in a PARITY state. A mismatch drops the byte and sets `frame_err`; the stop bit is still checked. Frame is 1+DATA_WIDTH+1+1 bits.
- `UART_RX_PARITY_EN` undefined: no PARITY state; frame is 1+DATA_WIDTH+1 bits.

## Structure
- Shared package `uart_pkg`: receive and issue FSM state enums, default `CLKS_PER_BIT`, the WAIT_BSY timeout constant (4).
- One sub-module, `byte_fifo`: synchronous FIFO with push, pop, full, empty and count; pointers carry an extra wrap bit.

## Test plan
- Frame 0xA5, CLKS_PER_BIT=16, master asserts `m_busy` 1 cycle after execute for 10 cycles → exactly one `m_execute`, `m_din`=0xA5, `fifo_count` returns to 0.
- 1-cycle low glitch on `rx` mid-bit-period in idle → START samples high, no push, no flags.
- Frame 0x3C with stop bit low → `frame_err`=1, no push. `err_clr` pulse → `frame_err`=0.
- Hold `m_busy`=1, send 5 bytes 0x01..0x05 → `fifo_count`=4, `overrun`=1. Release busy → executes deliver 0x01..0x04 in order.
- Reset asserted during DATA of a frame, then frame 0x7E → only 0x7E issued, outputs at reset values during reset.
- With `UART_RX_PARITY_EN` defined: 0x0F with parity 0 accepted. 0x0F with parity 1 → `frame_err`=1, no execute.
